// File: rtl/bitrev_rr_arbiter.sv
// bitrev_rr_arbiter
//   Round-robin arbiter that shares one registered bit-reversal stage among NUM_REQ
//   requesters. The granted word is bit-reversed into a single-entry output slot and
//   presented downstream with the index of the requester that supplied it.
//
// Ports
//   clk        : clock, all state on the rising edge
//   reset      : synchronous, active-high reset
//   req_valid  : per-requester valid
//   req_data   : requester i word at bits [i*DATA_W +: DATA_W]
//   req_ready  : per-requester ready, one-hot or zero
//   out_valid  : output slot holds a word
//   out_data   : bit-reversed accepted word
//   out_src    : index of the requester that supplied out_data
//   out_ready  : downstream accepts the word
//   xfer_count : completed output transfers, wraps at 16 bits
//   busy       : same as out_valid
module bitrev_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic [15:0]               xfer_count,
    output logic                      busy
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic [15:0]       count_q, count_d;

    logic              can_accept;
    logic              grant_found;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W-1:0]  scan_cand;
    int unsigned       scan_idx;
    logic [DATA_W-1:0] grant_word;
    logic [DATA_W-1:0] grant_rev;
    logic              accept;
    logic              drain;

    // Slot can take a new word when empty, or when it is being drained this edge.
    assign can_accept = (state_q == StEmpty) || out_ready;
    assign drain      = (state_q == StFull) && out_ready;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        scan_cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx  = (32'(rr_ptr_q) + k) % NUM_REQ;
            scan_cand = SRC_W'(scan_idx);
            if (!grant_found && req_valid[scan_cand]) begin
                grant_found = 1'b1;
                grant_idx   = scan_cand;
            end
        end
    end

    // Reset forces ready low so a handshake coinciding with reset is never taken.
    assign accept = grant_found && can_accept && !reset;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Word mux and bit reversal; only feeds registers, never an output directly.
    always_comb begin
        grant_word = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                grant_word = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        grant_rev = '0;
        for (int unsigned k = 0; k < DATA_W; k++) begin
            grant_rev[k] = grant_word[DATA_W-1-k];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StEmpty;
            rr_ptr_q <= '0;
            data_q   <= '0;
            src_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            src_q    <= src_d;
            count_q  <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        src_d    = src_q;
        count_d  = count_q;

        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                // Drain with simultaneous reload keeps the slot full.
                if (drain && !accept) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (accept) begin
            data_d   = grant_rev;
            src_d    = grant_idx;
            rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        if (drain) begin
            count_d = count_q + 16'd1;
        end
    end

    // Output logic
    always_comb begin
        out_valid  = (state_q == StFull);
        busy       = (state_q == StFull);
        out_data   = data_q;
        out_src    = src_q;
        xfer_count = count_q;
    end

endmodule

// File: tb/tb_bitrev_rr_arbiter.sv
module tb_bitrev_rr_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SRC_W   = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;
    logic [15:0]               xfer_count;
    logic                      busy;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] src;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_item;
    int   tests_run    = 0;
    int   tests_failed = 0;

    bitrev_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .xfer_count (xfer_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ready_during: got %b expected 0000", req_ready);
        end
        tick();
        tick();
        reset     = 1'b0;
        req_valid = 4'b0000;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        tests_run++;
        if (out_data !== 8'h00 || out_src !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h/%0d expected 00/0", out_data, out_src);
        end
        tests_run++;
        if (xfer_count !== 16'h0000 || req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_count: got cnt=%h rdy=%b expected 0000/0000", xfer_count,
                     req_ready);
        end
    endtask

    task automatic test_single();
        req_data  = {8'h00, 8'h00, 8'h00, 8'h12};
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        sb_q.push_back('{data: 8'h48, src: 2'd0});
        tick();
        req_valid = 4'b0000;
        #1;
        tests_run++;
        exp_item = sb_q.pop_front();
        if (out_valid !== 1'b1 || out_data !== exp_item.data || out_src !== exp_item.src) begin
            tests_failed++;
            $display("FAIL single_out: got v=%b %h/%0d expected v=1 %h/%0d", out_valid,
                     out_data, out_src, exp_item.data, exp_item.src);
        end
        tests_run++;
        if (xfer_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL single_cnt_pre: got %0d expected 0", xfer_count);
        end
        tick();
        tests_run++;
        if (xfer_count !== 16'd1 || out_valid !== 1'b0 || out_data !== 8'h48) begin
            tests_failed++;
            $display("FAIL single_drain: got cnt=%0d v=%b d=%h expected 1 0 48", xfer_count,
                     out_valid, out_data);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] rd [4] = '{8'h80, 8'hD0, 8'h0F, 8'h01};
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_data  = {8'h80, 8'hF0, 8'h0B, 8'h01};
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (req_ready !== 4'(1 << (i % 4))) begin
                tests_failed++;
                $display("FAIL simul_ready[%0d]: got %b expected %b", i, req_ready,
                         4'(1 << (i % 4)));
            end
            sb_q.push_back('{data: rd[i % 4], src: 2'(i % 4)});
            tick();
            exp_item = sb_q.pop_front();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp_item.data || out_src !== exp_item.src) begin
                tests_failed++;
                $display("FAIL simul_out[%0d]: got v=%b %h/%0d expected v=1 %h/%0d", i,
                         out_valid, out_data, out_src, exp_item.data, exp_item.src);
            end
        end
        tests_run++;
        if (xfer_count !== 16'd4) begin
            tests_failed++;
            $display("FAIL simul_cnt: got %0d expected 4", xfer_count);
        end
        req_valid = 4'b0000;
        tick();
        tests_run++;
        if (xfer_count !== 16'd5 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_drain: got cnt=%0d v=%b expected 5 0", xfer_count, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        req_data  = {8'h80, 8'h0B, 8'hA1, 8'h00};
        req_valid = 4'b0100;
        out_ready = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_fill_ready: got %b expected 0100", req_ready);
        end
        sb_q.push_back('{data: 8'hD0, src: 2'd2});
        tick();
        req_valid = 4'b0010;
        #1;
        exp_item = sb_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== exp_item.data || out_src !== exp_item.src) begin
            tests_failed++;
            $display("FAIL bp_fill_out: got v=%b %h/%0d expected v=1 %h/%0d", out_valid,
                     out_data, out_src, exp_item.data, exp_item.src);
        end
        for (int i = 0; i < 5; i++) begin
            if (req_ready !== 4'b0000 || out_data !== 8'hD0 || out_src !== 2'd2 ||
                out_valid !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got rdy=%b %h/%0d v=%b expected 0000 d0/2 v=1",
                         i, req_ready, out_data, out_src, out_valid);
            end
            tick();
        end
        tests_run++;
        if (bad != 0) tests_failed++;
        tests_run++;
        if (xfer_count !== 16'd5) begin
            tests_failed++;
            $display("FAIL bp_cnt_hold: got %0d expected 5", xfer_count);
        end
        req_valid = 4'b1010;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b expected 1000", req_ready);
        end
        sb_q.push_back('{data: 8'h01, src: 2'd3});
        tick();
        req_valid = 4'b0010;
        #1;
        exp_item = sb_q.pop_front();
        tests_run++;
        if (out_data !== exp_item.data || out_src !== exp_item.src || xfer_count !== 16'd6) begin
            tests_failed++;
            $display("FAIL bp_reload: got %h/%0d cnt=%0d expected %h/%0d cnt=6", out_data,
                     out_src, xfer_count, exp_item.data, exp_item.src);
        end
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_next_ready: got %b expected 0010", req_ready);
        end
        sb_q.push_back('{data: 8'h85, src: 2'd1});
        tick();
        req_valid = 4'b0000;
        exp_item  = sb_q.pop_front();
        tests_run++;
        if (out_data !== exp_item.data || out_src !== exp_item.src || xfer_count !== 16'd7) begin
            tests_failed++;
            $display("FAIL bp_req1: got %h/%0d cnt=%0d expected %h/%0d cnt=7", out_data,
                     out_src, xfer_count, exp_item.data, exp_item.src);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || xfer_count !== 16'd8) begin
            tests_failed++;
            $display("FAIL bp_final: got v=%b cnt=%0d expected 0 8", out_valid, xfer_count);
        end
    endtask

    task automatic test_rr_skip();
        // rr_ptr is 2 here; only requester 1 asks, so the scan wraps to it.
        req_data  = {8'h00, 8'h00, 8'h12, 8'h00};
        req_valid = 4'b0010;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL skip_ready: got %b expected 0010", req_ready);
        end
        sb_q.push_back('{data: 8'h48, src: 2'd1});
        tick();
        exp_item = sb_q.pop_front();
        tests_run++;
        if (out_data !== exp_item.data || out_src !== exp_item.src) begin
            tests_failed++;
            $display("FAIL skip_out: got %h/%0d expected %h/%0d", out_data, out_src,
                     exp_item.data, exp_item.src);
        end
        // rr_ptr must now be 2: with all valid, requester 2 wins.
        req_data  = {8'h01, 8'h03, 8'h02, 8'h04};
        req_valid = 4'b1111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL skip_ptr: got %b expected 0100", req_ready);
        end
        sb_q.push_back('{data: 8'hC0, src: 2'd2});
        tick();
        req_valid = 4'b0000;
        exp_item  = sb_q.pop_front();
        tests_run++;
        if (out_data !== exp_item.data || out_src !== exp_item.src) begin
            tests_failed++;
            $display("FAIL skip_next: got %h/%0d expected %h/%0d", out_data, out_src,
                     exp_item.data, exp_item.src);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        req_data  = {8'hC4, 8'h00, 8'h00, 8'h12};
        req_valid = 4'b0001;
        out_ready = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h48) begin
            tests_failed++;
            $display("FAIL rmid_fill: got v=%b %h expected 1 48", out_valid, out_data);
        end
        req_valid = 4'b1000;
        reset     = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rmid_ready_rst: got %b expected 0000", req_ready);
        end
        tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || xfer_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL rmid_state: got v=%b busy=%b cnt=%0d expected 0 0 0", out_valid,
                     busy, xfer_count);
        end
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL rmid_after_ready: got %b expected 1000", req_ready);
        end
        sb_q.push_back('{data: 8'h23, src: 2'd3});
        tick();
        req_valid = 4'b0000;
        exp_item  = sb_q.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== exp_item.data || out_src !== exp_item.src) begin
            tests_failed++;
            $display("FAIL rmid_out: got v=%b %h/%0d expected v=1 %h/%0d", out_valid,
                     out_data, out_src, exp_item.data, exp_item.src);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || xfer_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL rmid_drain: got v=%b cnt=%0d expected 0 1", out_valid, xfer_count);
        end
    endtask

    task automatic test_counter_wrap();
        int bad = 0;
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_data  = {8'h00, 8'h00, 8'h00, 8'h12};
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        // Edge e accepts a word and drains the previous one, so count = e-1.
        for (int e = 1; e <= 65537; e++) begin
            tick();
            if (out_valid !== 1'b1) bad++;
            if (e == 65536) begin
                tests_run++;
                if (xfer_count !== 16'hFFFF) begin
                    tests_failed++;
                    $display("FAIL wrap_ffff: got %h expected ffff", xfer_count);
                end
            end
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL wrap_valid: got %0d cycles with out_valid low expected 0", bad);
        end
        tests_run++;
        if (xfer_count !== 16'h0000 || out_data !== 8'h48) begin
            tests_failed++;
            $display("FAIL wrap_zero: got cnt=%h d=%h expected 0000 48", xfer_count, out_data);
        end
        req_valid = 4'b0000;
        tick();
        tests_run++;
        if (xfer_count !== 16'h0001 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_after: got cnt=%h v=%b expected 0001 0", xfer_count, out_valid);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_rr_skip();
        test_reset_mid();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
